spi_readback_tx: RTL and testbench

//  - SPI read path, paired with the write-side control unit. It decodes the frame
//    {addr MSB, addr LSB, instr, data}. On a read instruction it fetches the memory byte.
//  - It loads that byte into the MISO shift register, ready for the 4th byte slot.
//  - Sits between the SPI byte receiver (rx_byte/data_valid), the config memory read port
//    and the SPI transmit shifter.

---
 rtl/spi_pkg.sv | 32 +++
 rtl/spi_rd_latency_cnt.sv | 43 ++++
 rtl/spi_readback_tx.sv | 172 +++++++++++++++++
 tb/tb_spi_readback_tx.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave datapath: frame FSM states, instruction
// codes, bus widths and a small address helper.
package spi_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    // Instruction codes carried in the third frame byte
    localparam logic [DATA_W-1:0] INSTR_WRITE  = 8'h01;
    localparam logic [DATA_W-1:0] INSTR_READ   = 8'h03;
    localparam logic [DATA_W-1:0] INSTR_STATUS = 8'h05;
    localparam logic [DATA_W-1:0] INSTR_WR_EN  = 8'h07;
    localparam logic [DATA_W-1:0] INSTR_WR_DIS = 8'h09;

    // Frame sequencing states of the read path
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR_MSB = 3'd1,
        ST_ADDR_LSB = 3'd2,
        ST_INSTR    = 3'd3,
        ST_FETCH    = 3'd4,
        ST_WAIT_RD  = 3'd5,
        ST_WAIT_TX  = 3'd6,
        ST_DRAIN    = 3'd7
    } state_t;

    // Next sequential address; 16'hFFFF wraps to 16'h0000 by width truncation
    function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] addr);
        return ADDR_W'(addr + ADDR_W'(1));
    endfunction

endpackage

// File: rtl/spi_rd_latency_cnt.sv
// Memory read latency down-counter shared by memory-fetch paths.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : arm the counter; done_c rises LATENCY cycles later
//   clear      : abandon a pending count (start wins if both are high)
//   done_c     : combinational, high in the cycle read data is valid
module spi_rd_latency_cnt #(
    parameter int unsigned LATENCY = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic clear,
    output logic done_c
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [CNT_W-1:0] count;
    logic             active;

    // Start loads LATENCY-1 so done_c is high in the LATENCY-th cycle after start
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            active <= 1'b0;
        end else if (start) begin
            count  <= CNT_W'(LATENCY - 1);
            active <= 1'b1;
        end else if (clear) begin
            active <= 1'b0;
        end else if (active) begin
            if (count == '0) begin
                active <= 1'b0;
            end else begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign done_c = active && (count == '0);

endmodule

// File: rtl/spi_readback_tx.sv
// SPI read path: decodes {addr MSB, addr LSB, instr, data} frames, fetches the
// addressed memory byte on a read instruction and hands it to the MISO shifter
// for the fourth byte slot.
// Optional feature: define SPI_READBACK_BURST_EN to stream consecutive bytes
// (address auto-increment, wrapping at 16'hFFFF) while cs stays low.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   cs          : chip select, active low
//   data_valid  : 1-cycle pulse, rx_byte holds a complete byte
//   rx_byte     : received byte
//   mem_rdata   : memory read data
//   mem_addr    : read address {MSB, LSB}
//   mem_rd_en   : 1-cycle memory read strobe
//   tx_byte     : byte presented to the MISO shifter
//   tx_load     : 1-cycle pulse, shifter loads tx_byte
//   busy        : frame in progress
//   overrun     : sticky, a byte arrived before read data was loaded
module spi_readback_tx
    import spi_pkg::*;
#(
    parameter logic [DATA_W-1:0] READ_INSTR  = INSTR_READ,
    parameter int unsigned       MEM_LATENCY = 1,
    parameter logic [DATA_W-1:0] IDLE_FILL   = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] rx_byte,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic [DATA_W-1:0] tx_byte,
    output logic              tx_load,
    output logic              busy,
    output logic              overrun
);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] addr_msb, addr_msb_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic              mem_rd_en_nxt;
    logic [DATA_W-1:0] tx_byte_nxt;
    logic              tx_load_nxt;
    logic              busy_nxt;
    logic              overrun_nxt;
    logic              cnt_start_c;
    logic              cnt_clear_c;
    logic              cnt_done_c;

    spi_rd_latency_cnt #(
        .LATENCY (MEM_LATENCY)
    ) u_lat_cnt (
        .clk    (clk),
        .reset  (reset),
        .start  (cnt_start_c),
        .clear  (cnt_clear_c),
        .done_c (cnt_done_c)
    );

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            addr_msb  <= '0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            tx_byte   <= IDLE_FILL;
            tx_load   <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr_msb  <= addr_msb_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_rd_en <= mem_rd_en_nxt;
            tx_byte   <= tx_byte_nxt;
            tx_load   <= tx_load_nxt;
            busy      <= busy_nxt;
            overrun   <= overrun_nxt;
        end
    end

    // Next state and next output values
    always_comb begin
        state_nxt     = state;
        addr_msb_nxt  = addr_msb;
        mem_addr_nxt  = mem_addr;
        mem_rd_en_nxt = 1'b0;
        tx_byte_nxt   = tx_byte;
        tx_load_nxt   = 1'b0;
        busy_nxt      = busy;
        overrun_nxt   = overrun;
        cnt_start_c   = 1'b0;
        cnt_clear_c   = 1'b0;

        if (cs) begin
            // Deselect aborts everything, including an in-flight fetch;
            // a data_valid in the same cycle is dropped.
            state_nxt   = ST_IDLE;
            busy_nxt    = 1'b0;
            tx_byte_nxt = IDLE_FILL;
            cnt_clear_c = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt   = ST_ADDR_MSB;
                    busy_nxt    = 1'b1;
                    overrun_nxt = 1'b0;
                end
                ST_ADDR_MSB: begin
                    if (data_valid) begin
                        addr_msb_nxt = rx_byte;
                        state_nxt    = ST_ADDR_LSB;
                    end
                end
                ST_ADDR_LSB: begin
                    if (data_valid) begin
                        mem_addr_nxt = {addr_msb, rx_byte};
                        state_nxt    = ST_INSTR;
                    end
                end
                ST_INSTR: begin
                    if (data_valid) begin
                        if (rx_byte == READ_INSTR) begin
                            state_nxt     = ST_FETCH;
                            mem_rd_en_nxt = 1'b1;
                        end else begin
                            state_nxt = ST_DRAIN;
                        end
                    end
                end
                ST_FETCH: begin
                    cnt_start_c = 1'b1;
                    state_nxt   = ST_WAIT_RD;
                    if (data_valid) begin
                        overrun_nxt = 1'b1;
                    end
                end
                ST_WAIT_RD: begin
                    if (data_valid) begin
                        overrun_nxt = 1'b1;
                    end
                    // An overrun still delivers the byte but ends the data phase
                    if (cnt_done_c) begin
                        tx_byte_nxt = mem_rdata;
                        tx_load_nxt = 1'b1;
                        state_nxt   = (overrun || data_valid) ? ST_DRAIN : ST_WAIT_TX;
                    end
                end
                ST_WAIT_TX: begin
                    if (data_valid) begin
`ifdef SPI_READBACK_BURST_EN
                        state_nxt     = ST_FETCH;
                        mem_rd_en_nxt = 1'b1;
                        mem_addr_nxt  = addr_next(mem_addr);
`else
                        state_nxt = ST_DRAIN;
`endif
                    end
                end
                ST_DRAIN: begin
                    state_nxt = ST_DRAIN;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_readback_tx.sv
// Directed bench for spi_readback_tx: one instance with MEM_LATENCY=1 and one
// with MEM_LATENCY=4 share the same SPI stimulus; each has its own memory model.
module tb_spi_readback_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic        data_valid;
    logic [7:0]  rx_byte;

    logic [7:0]  mem_rdata1, mem_rdata4;
    logic [15:0] mem_addr1, mem_addr4;
    logic        mem_rd_en1, mem_rd_en4;
    logic [7:0]  tx_byte1, tx_byte4;
    logic        tx_load1, tx_load4;
    logic        busy1, busy4;
    logic        overrun1, overrun4;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] rd_q1[$], rd_q4[$];
    logic [7:0]  ld_q1[$], ld_q4[$];

    logic [2:0]  p4_v = '0;
    logic [15:0] p4_a0, p4_a1, p4_a2;

    always #5 clk = ~clk;

    spi_readback_tx #(.READ_INSTR(8'h03), .MEM_LATENCY(1), .IDLE_FILL(8'h00)) u_dut1 (
        .clk(clk), .reset(reset), .cs(cs), .data_valid(data_valid), .rx_byte(rx_byte),
        .mem_rdata(mem_rdata1), .mem_addr(mem_addr1), .mem_rd_en(mem_rd_en1),
        .tx_byte(tx_byte1), .tx_load(tx_load1), .busy(busy1), .overrun(overrun1)
    );

    spi_readback_tx #(.READ_INSTR(8'h03), .MEM_LATENCY(4), .IDLE_FILL(8'h00)) u_dut4 (
        .clk(clk), .reset(reset), .cs(cs), .data_valid(data_valid), .rx_byte(rx_byte),
        .mem_rdata(mem_rdata4), .mem_addr(mem_addr4), .mem_rd_en(mem_rd_en4),
        .tx_byte(tx_byte4), .tx_load(tx_load4), .busy(busy4), .overrun(overrun4)
    );

    // Memory contents: 16'h1234 holds 8'hA5, everything else is addr[7:0]^8'h3C
    function automatic logic [7:0] mem_f(input logic [15:0] a);
        if (a == 16'h1234) return 8'hA5;
        return a[7:0] ^ 8'h3C;
    endfunction

    // Memories drive valid data only in the exact latency cycle, 8'hEE otherwise
    always @(posedge clk) begin
        mem_rdata1 <= mem_rd_en1 ? mem_f(mem_addr1) : 8'hEE;
        p4_v       <= {p4_v[1:0], mem_rd_en4};
        p4_a0      <= mem_addr4;
        p4_a1      <= p4_a0;
        p4_a2      <= p4_a1;
        mem_rdata4 <= p4_v[2] ? mem_f(p4_a2) : 8'hEE;
    end

    // Log every read strobe address and every loaded byte
    always @(negedge clk) begin
        if (mem_rd_en1) rd_q1.push_back(mem_addr1);
        if (mem_rd_en4) rd_q4.push_back(mem_addr4);
        if (tx_load1)   ld_q1.push_back(tx_byte1);
        if (tx_load4)   ld_q4.push_back(tx_byte4);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        data_valid = 1'b1;
        rx_byte    = b;
        tick();
        data_valid = 1'b0;
    endtask

    task automatic start_frame();
        cs = 1'b0;
        tick();
    endtask

    task automatic end_frame();
        cs = 1'b1;
        tick();
    endtask

    task automatic clear_logs();
        rd_q1.delete();
        rd_q4.delete();
        ld_q1.delete();
        ld_q4.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] exp_a[4];
        logic [7:0]  exp_d[4];
        int          exp_n;

        reset      = 1'b1;
        cs         = 1'b0;
        data_valid = 1'b0;
        rx_byte    = 8'h00;

        // T1: reset with cs low
        idle(2);
        check("rst_busy",    32'(busy1),      32'h0);
        check("rst_rd_en",   32'(mem_rd_en1), 32'h0);
        check("rst_load",    32'(tx_load1),   32'h0);
        check("rst_overrun", 32'(overrun1),   32'h0);
        check("rst_addr",    32'(mem_addr1),  32'h0);
        check("rst_tx_byte", 32'(tx_byte1),   32'h0);
        check("rst_busy4",   32'(busy4),      32'h0);
        reset = 1'b0;
        tick();
        check("rel_busy",    32'(busy1),      32'h1);
        end_frame();
        check("rel_cs_busy", 32'(busy1),      32'h0);

        // T2: basic read, memory[16'h1234]=8'hA5
        clear_logs();
        start_frame();
        check("t2_busy", 32'(busy1), 32'h1);
        send(8'h12);
        send(8'h34);
        check("t2_addr1", 32'(mem_addr1), 32'h1234);
        check("t2_addr4", 32'(mem_addr4), 32'h1234);
        check("t2_rd_en_pre", 32'(mem_rd_en1), 32'h0);
        send(8'h03);
        check("t2_rd_en_t1",  32'(mem_rd_en1), 32'h1);
        check("t2_rd_en4_t1", 32'(mem_rd_en4), 32'h1);
        tick();
        check("t2_rd_en_t2", 32'(mem_rd_en1), 32'h0);
        check("t2_load_t2",  32'(tx_load1),   32'h0);
        tick();
        check("t2_load_t3",  32'(tx_load1),   32'h1);
        check("t2_byte_t3",  32'(tx_byte1),   32'hA5);
        tick();
        check("t2_load_t4",  32'(tx_load1),   32'h0);
        check("t2_hold_t4",  32'(tx_byte1),   32'hA5);
        tick();
        check("t2_load4_t5", 32'(tx_load4),   32'h0);
        tick();
        check("t2_load4_t6", 32'(tx_load4),   32'h1);
        check("t2_byte4_t6", 32'(tx_byte4),   32'hA5);
        check("t2_rd_cnt",   32'(rd_q1.size()), 32'd1);
        end_frame();
        check("t2_cs_byte1", 32'(tx_byte1), 32'h00);
        check("t2_cs_byte4", 32'(tx_byte4), 32'h00);
        check("t2_cs_busy",  32'(busy1),    32'h0);

        // T3: non-read instruction
        clear_logs();
        start_frame();
        send(8'h00);
        send(8'h10);
        send(8'h05);
        send(8'hFF);
        idle(6);
        check("t3_busy1",  32'(busy1), 32'h1);
        check("t3_busy4",  32'(busy4), 32'h1);
        check("t3_addr",   32'(mem_addr1), 32'h0010);
        check("t3_rd1",    32'(rd_q1.size()), 32'd0);
        check("t3_rd4",    32'(rd_q4.size()), 32'd0);
        check("t3_load1",  32'(ld_q1.size()), 32'd0);
        check("t3_load4",  32'(ld_q4.size()), 32'd0);
        end_frame();
        check("t3_cs_busy", 32'(busy1), 32'h0);

        // T4: abort in the cycle after mem_rd_en
        clear_logs();
        start_frame();
        send(8'h00);
        send(8'h01);
        send(8'h03);
        tick();
        cs = 1'b1;
        tick();
        check("t4_busy",  32'(busy1),   32'h0);
        check("t4_byte",  32'(tx_byte1), 32'h00);
        idle(6);
        check("t4_rd1",   32'(rd_q1.size()), 32'd1);
        check("t4_load1", 32'(ld_q1.size()), 32'd0);
        check("t4_load4", 32'(ld_q4.size()), 32'd0);
        check("t4_idle_byte4", 32'(tx_byte4), 32'h00);
        clear_logs();
        start_frame();
        send(8'h00);
        send(8'h02);
        send(8'h03);
        idle(8);
        check("t4b_load1_n", 32'(ld_q1.size()), 32'd1);
        check("t4b_load4_n", 32'(ld_q4.size()), 32'd1);
        if (ld_q1.size() > 0) check("t4b_data1", 32'(ld_q1[0]), 32'h3E);
        if (ld_q4.size() > 0) check("t4b_data4", 32'(ld_q4[0]), 32'h3E);
        check("t4b_ovr1", 32'(overrun1), 32'h0);
        check("t4b_ovr4", 32'(overrun4), 32'h0);
        end_frame();

        // T5: overrun, 4th-byte dv at T+2
        clear_logs();
        start_frame();
        send(8'h00);
        send(8'h40);
        send(8'h03);
        tick();
        send(8'hAA);
        check("t5_ovr4", 32'(overrun4), 32'h1);
        check("t5_ovr1", 32'(overrun1), 32'h1);
        check("t5_no_early_load4", 32'(ld_q4.size()), 32'd0);
        idle(5);
        check("t5_load4_n", 32'(ld_q4.size()), 32'd1);
        if (ld_q4.size() > 0) check("t5_data4", 32'(ld_q4[0]), 32'h7C);
        check("t5_load1_n", 32'(ld_q1.size()), 32'd1);
        if (ld_q1.size() > 0) check("t5_data1", 32'(ld_q1[0]), 32'h7C);
        send(8'h55);
        idle(6);
        check("t5_drain_rd4",   32'(rd_q4.size()), 32'd1);
        check("t5_drain_load4", 32'(ld_q4.size()), 32'd1);
        check("t5_drain_rd1",   32'(rd_q1.size()), 32'd1);
        end_frame();
        check("t5_sticky4", 32'(overrun4), 32'h1);
        start_frame();
        check("t5_clr4", 32'(overrun4), 32'h0);
        check("t5_clr1", 32'(overrun1), 32'h0);
        end_frame();

        // T6: burst from 16'hFFFE, 4 data slots
        clear_logs();
        start_frame();
        send(8'hFF);
        send(8'hFE);
        send(8'h03);
        idle(6);
        for (int i = 0; i < 3; i++) begin
            send(8'h00);
            idle(7);
        end
        data_valid = 1'b1;
        rx_byte    = 8'h00;
        cs         = 1'b1;
        tick();
        data_valid = 1'b0;
        idle(6);
`ifdef SPI_READBACK_BURST_EN
        exp_n = 4;
`else
        exp_n = 1;
`endif
        exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        exp_d = '{8'hC2, 8'hC3, 8'h3C, 8'h3D};
        check("t6_rd_n1",   32'(rd_q1.size()), 32'(exp_n));
        check("t6_rd_n4",   32'(rd_q4.size()), 32'(exp_n));
        check("t6_load_n4", 32'(ld_q4.size()), 32'(exp_n));
        for (int i = 0; i < exp_n; i++) begin
            if (i < rd_q4.size()) check($sformatf("t6_addr4_%0d", i), 32'(rd_q4[i]), 32'(exp_a[i]));
            if (i < ld_q4.size()) check($sformatf("t6_data4_%0d", i), 32'(ld_q4[i]), 32'(exp_d[i]));
            if (i < rd_q1.size()) check($sformatf("t6_addr1_%0d", i), 32'(rd_q1[i]), 32'(exp_a[i]));
        end
        check("t6_end_byte", 32'(tx_byte4), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
